mips_multicycle_core: RTL and testbench

Multicycle MIPS-subset core: the successor to the single-cycle top-level. It uses one shared instruction/data memory port with a request/ready handshake, so memory may insert wait states, and a control FSM that sequences each instruction over several cycles. It sits between the team's register file and ALU on one side and a unified memory or bus adapter on the other. Parametrised reset vector and address width; illegal or misaligned operations halt the core.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/mips_multicycle_core_if.sv | 14 +
 rtl/alu.sv | 19 +
 rtl/mc_control_fsm.sv | 73 +++++++
 rtl/register_file.sv | 25 ++
 rtl/mips_multicycle_core.sv | 95 +++++++++
 tb/tb_mips_multicycle_core.sv | 299 +++++++++++++++++++++++++++++
 7 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, ALU control encodings and control FSM state type
// for the multicycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
  } state_t;

  function automatic logic funct_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic logic [2:0] alu_ctrl_of(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory port with request/ready handshake.
interface mips_multicycle_core_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/alu.sv
// 32-bit ALU: and/or/add/sub/signed slt; overflow is not reported.
module alu
  import mips_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_y
);
  always_comb begin
    case (i_ctrl)
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_SLT: o_y = {31'b0, ($signed(i_a) < $signed(i_b))};
      default: o_y = i_a + i_b;
    endcase
  end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: state register, next-state decode, registered bus strobes.
// MIPS_JUMP_EN enables decoding of j (opcode 000010); otherwise it halts the core.
module mc_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic [1:0] i_ea_lo,
  input  logic       i_mem_ready,
  output state_t     o_state,
  output state_t     o_nstate,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_halted
);
`ifdef MIPS_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  state_t r_state, w_nstate;
  logic   r_mem_req, r_mem_we, r_halted;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_RST:    w_nstate = FETCH;
      FETCH:    if (i_mem_ready) w_nstate = DECODE;
      DECODE: begin
        case (i_op)
          OP_LW, OP_SW: w_nstate = MEMADR;
          OP_RTYPE:     w_nstate = funct_ok(i_funct) ? EXECUTE : HALT;
          OP_BEQ:       w_nstate = BRANCH;
          OP_ADDI:      w_nstate = ADDIEX;
          OP_J:         w_nstate = JUMP_EN ? JUMP : HALT;
          default:      w_nstate = HALT;
        endcase
      end
      MEMADR:   w_nstate = (i_ea_lo != 2'b00) ? HALT :
                           (i_op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (i_mem_ready) w_nstate = MEMWB;
      MEMWRITE: if (i_mem_ready) w_nstate = FETCH;
      EXECUTE:  w_nstate = ALUWB;
      ADDIEX:   w_nstate = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: w_nstate = FETCH;
      default:  w_nstate = HALT;
    endcase
  end

  // Bus strobes are registered from the next state so they are valid for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_mem_req <= w_nstate inside {FETCH, MEMREAD, MEMWRITE};
      r_mem_we  <= (w_nstate == MEMWRITE);
      r_halted  <= (w_nstate == HALT);
    end
  end

  assign o_state   = r_state;
  assign o_nstate  = w_nstate;
  assign o_mem_req = r_mem_req;
  assign o_mem_we  = r_mem_we;
  assign o_halted  = r_halted;
endmodule

// File: rtl/register_file.sv
// 32x32 register file, two async read ports, one sync write port; $0 is hardwired zero.
module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] r_regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];
endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core top: datapath registers around register_file and alu,
// sequenced by mc_control_fsm. j support is compiled in with MIPS_JUMP_EN.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mips_multicycle_core_if.master bus,
  output logic        halted,
  output logic [31:0] pc_out
);
  logic [31:0]       r_pc, r_ir, r_aluout, r_mdr, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  state_t            w_state, w_nstate;
  logic              w_mem_req, w_mem_we, w_halted;
  logic [31:0]       w_rs_d, w_rt_d, w_simm, w_src_a, w_src_b, w_alu_y, w_pc_next, w_wd;
  logic [2:0]        w_alu_ctrl;
  logic              w_rf_we;
  logic [4:0]        w_wa;

  assign w_simm = {{16{r_ir[15]}}, r_ir[15:0]};

  mc_control_fsm u_fsm (
    .clk(clk), .rst_n(rst_n), .i_op(r_ir[31:26]), .i_funct(r_ir[5:0]),
    .i_ea_lo(w_alu_y[1:0]), .i_mem_ready(bus.mem_ready),
    .o_state(w_state), .o_nstate(w_nstate),
    .o_mem_req(w_mem_req), .o_mem_we(w_mem_we), .o_halted(w_halted)
  );

  register_file u_rf (
    .clk(clk), .rst_n(rst_n), .i_ra1(r_ir[25:21]), .i_ra2(r_ir[20:16]),
    .i_we(w_rf_we), .i_wa(w_wa), .i_wd(w_wd), .o_rd1(w_rs_d), .o_rd2(w_rt_d)
  );

  // DECODE borrows the ALU for the branch target; memory/addi states use rs + SignImm.
  always_comb begin
    w_src_a    = w_rs_d;
    w_src_b    = w_simm;
    w_alu_ctrl = ALU_ADD;
    case (w_state)
      DECODE:  begin w_src_a = r_pc; w_src_b = {w_simm[29:0], 2'b00}; end
      EXECUTE: begin w_src_b = w_rt_d; w_alu_ctrl = alu_ctrl_of(r_ir[5:0]); end
      default: ;
    endcase
  end

  alu u_alu (.i_a(w_src_a), .i_b(w_src_b), .i_ctrl(w_alu_ctrl), .o_y(w_alu_y));

  always_comb begin
    w_pc_next = r_pc;
    case (w_state)
      FETCH:   if (bus.mem_ready) w_pc_next = r_pc + 32'd4;
      BRANCH:  if (w_rs_d == w_rt_d) w_pc_next = r_aluout;
      JUMP:    w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      default: ;
    endcase
  end

  assign w_rf_we = w_state inside {MEMWB, ALUWB, ADDIWB};
  assign w_wa    = (w_state == ALUWB) ? r_ir[15:11] : r_ir[20:16];
  assign w_wd    = (w_state == MEMWB) ? r_mdr : r_aluout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_aluout    <= '0;
      r_mdr       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_state == FETCH && bus.mem_ready) r_ir <= bus.mem_rdata;
      if (w_state == MEMREAD && bus.mem_ready) r_mdr <= bus.mem_rdata;
      if (w_state inside {DECODE, MEMADR, EXECUTE, ADDIEX}) r_aluout <= w_alu_y;
      // Address/data are loaded once on entry to a memory state and held until accepted.
      if (w_nstate == FETCH && w_state != FETCH) begin
        r_mem_addr <= w_pc_next[ADDR_W-1:0];
      end else if (w_state == MEMADR) begin
        r_mem_addr  <= w_alu_y[ADDR_W-1:0];
        r_mem_wdata <= w_rt_d;
      end
    end
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign halted        = w_halted;
  assign pc_out        = r_pc;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: ISA-level model predicts bus transactions and cycle
// counts; a memory responder checks every accepted request; directed programs add literals.
module tb_mips_multicycle_core;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ILL      = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted;
  logic [31:0] pc_out;

  mips_multicycle_core_if #(.ADDR_W(32)) bus();

  mips_multicycle_core #(.RESET_PC(RESET_PC), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .halted(halted), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  txn_t        expq[$];
  logic [31:0] img [128];
  logic [31:0] mem [128];
  logic [31:0] mm  [128];
  int          rw, ww, edges;
  int          n_cmp = 0, n_fail = 0;
  int          mexp_cyc;
  logic [31:0] mexp_pc;
  logic        mexp_halt;
  int          last_wr_len;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Instruction-set model: emits expected bus transactions and total cycles to HALT.
  task automatic model_run(input int max_steps);
    logic [31:0] r [32];
    logic [31:0] pc, ins, imm, a, b, res, ea;
    logic        hlt;
    int          steps;
    for (int i = 0; i < 32; i++) r[i] = 0;
    pc = RESET_PC; mexp_cyc = 1; hlt = 0; steps = 0;
    while (!hlt && steps < max_steps) begin
      steps++;
      expq.push_back('{1'b0, pc, 32'd0});
      ins = mm[pc[8:2]];
      pc  = pc + 4;
      mexp_cyc += 2 + rw;
      imm = {{16{ins[15]}}, ins[15:0]};
      a = r[ins[25:21]]; b = r[ins[20:16]];
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: hlt = 1;
          endcase
          if (!hlt) begin
            mexp_cyc += 2;
            if (ins[15:11] != 0) r[ins[15:11]] = res;
          end
        end
        6'h08: begin
          mexp_cyc += 2;
          if (ins[20:16] != 0) r[ins[20:16]] = a + imm;
        end
        6'h23, 6'h2B: begin
          ea = a + imm;
          mexp_cyc += 1;
          if (ea[1:0] != 0) hlt = 1;
          else if (ins[31:26] == 6'h23) begin
            expq.push_back('{1'b0, ea, 32'd0});
            mexp_cyc += 2 + rw;
            if (ins[20:16] != 0) r[ins[20:16]] = mm[ea[8:2]];
          end else begin
            expq.push_back('{1'b1, ea, b});
            mexp_cyc += 1 + ww;
            mm[ea[8:2]] = b;
          end
        end
        6'h04: begin
          mexp_cyc += 1;
          if (a == b) pc = pc + {imm[29:0], 2'b00};
        end
`ifdef MIPS_JUMP_EN
        6'h02: begin
          mexp_cyc += 1;
          pc = {pc[31:28], ins[25:0], 2'b00};
        end
`endif
        default: hlt = 1;
      endcase
    end
    mexp_pc = pc; mexp_halt = hlt;
  endtask

  // Memory responder and transaction checker.
  initial begin : responder
    int          wcnt, req_len;
    logic [31:0] hold_addr;
    txn_t        t;
    wcnt = 0; req_len = 0; hold_addr = 0; last_wr_len = 0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mem_ready = 1'b0; wcnt = 0; req_len = 0;
      end else begin
        if (halted) chk("no_req_in_halt", {31'd0, bus.mem_req}, 32'd0);
        if (bus.mem_req) begin
          req_len++;
          if (req_len == 1) hold_addr = bus.mem_addr;
          else chk("addr_hold", bus.mem_addr, hold_addr);
          if (wcnt < (bus.mem_we ? ww : rw)) begin
            bus.mem_ready = 1'b0; wcnt++;
          end else begin
            bus.mem_ready = 1'b1;
            if (expq.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL unexpected_req: got addr %h expected no request", bus.mem_addr);
            end else begin
              t = expq.pop_front();
              chk("txn_we", {31'd0, bus.mem_we}, {31'd0, t.we});
              chk("txn_addr", bus.mem_addr, t.addr);
              if (t.we) chk("txn_wdata", bus.mem_wdata, t.data);
            end
            if (bus.mem_we) begin
              mem[bus.mem_addr[8:2]] = bus.mem_wdata;
              last_wr_len = req_len;
            end else begin
              bus.mem_rdata = mem[bus.mem_addr[8:2]];
            end
            wcnt = 0; req_len = 0;
          end
        end else begin
          bus.mem_ready = 1'b0; wcnt = 0; req_len = 0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    edges++;
  endtask

  task automatic start_prog(input int rw_i, input int ww_i, input int steps);
    @(negedge clk);
    rst_n = 1'b0;
    rw = rw_i; ww = ww_i;
    for (int i = 0; i < 128; i++) begin mem[i] = img[i]; mm[i] = img[i]; end
    expq.delete();
    model_run(steps);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  task automatic run_to_halt(input string nm, input int budget);
    while (!halted && edges < budget) step();
    chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
    chk({nm, "_model_cycles"}, edges, mexp_cyc);
    chk({nm, "_model_pc"}, pc_out, mexp_pc);
    chk({nm, "_txn_left"}, expq.size(), 0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 128; i++) img[i] = ILL;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int found;
    rst_n = 1'b0; rw = 0; ww = 0; edges = 0;
    repeat (2) @(negedge clk);
    chk("rst_req",    {31'd0, bus.mem_req}, 32'd0);
    chk("rst_we",     {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr",   bus.mem_addr, 32'd0);
    chk("rst_wdata",  bus.mem_wdata, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc",     pc_out, RESET_PC);

    // A: addi/add then sw with a slow write
    clear_img();
    img[0] = enc_i(6'h08, 0, 1, 16'd5);
    img[1] = enc_r(6'h20, 1, 1, 2);
    img[2] = enc_i(6'h2B, 0, 2, 16'd4);
    start_prog(0, 3, 100);
    repeat (9) step();
    chk("A_pc_after_8", pc_out, 32'd8);
    run_to_halt("A", 200);
    chk("A_cycles", edges, 18);
    chk("A_pc", pc_out, 32'd16);
    chk("A_sw_data", mem[1], 32'd10);
    chk("A_sw_req_len", last_wr_len, 4);

    // B: lw DEADBEEF, store it back, with one fetch/read wait state
    clear_img();
    img[0] = enc_i(6'h23, 0, 3, 16'd12);
    img[1] = enc_i(6'h2B, 0, 3, 16'd16);
    img[3] = 32'hDEAD_BEEF;
    start_prog(1, 0, 100);
    run_to_halt("B", 200);
    chk("B_cycles", edges, 16);
    chk("B_lw_data", mem[4], 32'hDEAD_BEEF);

    // C: ALU ops, signed slt, branches, $0 discard, j
    clear_img();
    img[0]  = enc_i(6'h08, 0, 1, 16'hFFFD);
    img[1]  = enc_i(6'h08, 0, 2, 16'd2);
    img[2]  = enc_r(6'h2A, 1, 2, 3);
    img[3]  = enc_r(6'h22, 2, 1, 4);
    img[4]  = enc_i(6'h04, 1, 2, 16'd7);
    img[5]  = enc_r(6'h24, 4, 2, 5);
    img[6]  = enc_r(6'h25, 4, 2, 6);
    img[7]  = enc_i(6'h04, 3, 3, 16'd1);
    img[9]  = enc_i(6'h2B, 0, 3, 16'h40);
    img[10] = enc_i(6'h2B, 0, 4, 16'h44);
    img[11] = enc_i(6'h2B, 0, 5, 16'h48);
    img[12] = enc_i(6'h2B, 0, 6, 16'h4C);
    img[13] = enc_r(6'h20, 4, 4, 0);
    img[14] = enc_i(6'h2B, 0, 0, 16'h50);
    img[15] = {6'h02, 26'h40};
    img[18] = 32'hFFFF_FFFF;
    img[20] = 32'hFFFF_FFFF;
    start_prog(0, 0, 100);
    run_to_halt("C", 400);
`ifdef MIPS_JUMP_EN
    chk("C_cycles", edges, 60);
    chk("C_pc", pc_out, 32'h104);
`else
    chk("C_cycles", edges, 57);
    chk("C_pc", pc_out, 32'h40);
`endif
    chk("C_slt", mem[16], 32'd1);
    chk("C_sub", mem[17], 32'd5);
    chk("C_and", mem[18], 32'd0);
    chk("C_or",  mem[19], 32'd7);
    chk("C_r0",  mem[20], 32'd0);

    // D: beq -1 self-loop at 0x10, then reset mid-access
    clear_img();
    for (int i = 0; i < 4; i++) img[i] = enc_i(6'h08, 0, 1, 16'd7);
    img[4] = enc_i(6'h04, 1, 1, 16'hFFFF);
    start_prog(1, 0, 60);
    repeat (23) step();
    chk("D_pc_after_fetch", pc_out, 32'h14);
    repeat (2) step();
    chk("D_pc_loop", pc_out, 32'h10);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      #2;
      if (bus.mem_req && !bus.mem_ready) found = 1;
    end
    chk("D_wait_seen", found, 1);
    rst_n = 1'b0;
    #1;
    chk("D_abort_req", {31'd0, bus.mem_req}, 32'd0);
    chk("D_abort_pc", pc_out, RESET_PC);
    chk("D_abort_halted", {31'd0, halted}, 32'd0);

    // E: misaligned lw halts; reset clears it
    clear_img();
    img[0] = enc_i(6'h23, 0, 1, 16'd6);
    start_prog(0, 0, 10);
    run_to_halt("E", 50);
    chk("E_cycles", edges, 4);
    repeat (5) step();
    chk("E_req_idle", {31'd0, bus.mem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("E_rst_halted", {31'd0, halted}, 32'd0);
    chk("E_rst_pc", pc_out, RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
